// File: rtl/imem_prefetch.sv
// Instruction prefetch buffer between the core fetch port and a request/grant
// instruction memory with in-order read responses. It runs ahead of the core on
// sequential addresses into a small circular buffer of tagged entries. When the
// core jumps, it flushes the buffer and discards responses that are still in flight.
module imem_prefetch #(
   parameter int DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IADDR,
   output logic [31:0] IDATA,
   output logic        IVALID,
   output logic        MEM_REQ,
   output logic [31:0] MEM_ADDR,
   input  logic        MEM_GNT,
   input  logic        MEM_RVALID,
   input  logic [31:0] MEM_RDATA
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t         state_q, state_d;
   logic [31:0]    fptr_q, fptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [CW-1:0]  nfill_q, nfill_d;
   logic [CW-1:0]  drop_q, drop_d;
   logic [PW-1:0]  head_q, head_d;
   logic [PW-1:0]  tail_q, tail_d;
   logic [PW-1:0]  fill_q, fill_d;
   logic [31:0]    ent_addr_q [DEPTH];
   logic [31:0]    ent_addr_d [DEPTH];
   logic [31:0]    ent_data_q [DEPTH];
   logic [31:0]    ent_data_d [DEPTH];
   logic [DEPTH-1:0] ent_filled_q, ent_filled_d;

   logic [CW-1:0]  unfilled;
   logic           head_filled;
   logic [31:0]    head_addr;
   logic [31:0]    head_next;
   logic           hit;
   logic           pop;
   logic           redirect;
   logic           grant;
   logic           fill_now;

   // Head-of-buffer decode: hit, pop and redirect detection against the core address.
   always_comb begin
      unfilled    = count_q - nfill_q;
      head_filled = (count_q != '0) && ent_filled_q[head_q];
      head_addr   = ent_addr_q[head_q];
      head_next   = head_addr + 32'd4;
      hit         = head_filled && (head_addr == IADDR);
      pop         = head_filled && (head_next == IADDR);
      if (count_q != '0) begin
         redirect = !((IADDR == head_addr) || pop);
      end else begin
         redirect = (IADDR != fptr_q);
      end
   end

   // Next-state, buffer update and output logic for the IDLE/RUN/DRAIN controller.
   always_comb begin
      state_d      = state_q;
      fptr_d       = fptr_q;
      count_d      = count_q;
      nfill_d      = nfill_q;
      drop_d       = drop_q;
      head_d       = head_q;
      tail_d       = tail_q;
      fill_d       = fill_q;
      ent_addr_d   = ent_addr_q;
      ent_data_d   = ent_data_q;
      ent_filled_d = ent_filled_q;
      grant        = 1'b0;
      fill_now     = 1'b0;
      MEM_REQ      = 1'b0;
      MEM_ADDR     = fptr_q;
      IVALID       = 1'b0;
      IDATA        = 32'h0;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_RUN;
            fptr_d  = IADDR;
         end

         ST_RUN: begin
            IVALID = hit;
            IDATA  = hit ? ent_data_q[head_q] : 32'h0;
            if (redirect) begin
               fill_now     = MEM_RVALID && (unfilled != '0);
               drop_d       = unfilled - (fill_now ? ONE_C : '0);
               count_d      = '0;
               nfill_d      = '0;
               head_d       = '0;
               tail_d       = '0;
               fill_d       = '0;
               ent_filled_d = '0;
               fptr_d       = IADDR;
               state_d      = (drop_d != '0) ? ST_DRAIN : ST_RUN;
            end else begin
               MEM_REQ  = (count_q < DEPTH_C);
               grant    = MEM_REQ && MEM_GNT;
               fill_now = MEM_RVALID && (unfilled != '0);
               if (grant) begin
                  ent_addr_d[tail_q]   = fptr_q;
                  ent_filled_d[tail_q] = 1'b0;
                  tail_d               = tail_q + 1'b1;
                  fptr_d               = fptr_q + 32'd4;
               end
               if (fill_now) begin
                  ent_data_d[fill_q]   = MEM_RDATA;
                  ent_filled_d[fill_q] = 1'b1;
                  fill_d               = fill_q + 1'b1;
               end
               if (pop) begin
                  head_d = head_q + 1'b1;
               end
               count_d = count_q + (grant ? ONE_C : '0) - (pop ? ONE_C : '0);
               nfill_d = nfill_q + (fill_now ? ONE_C : '0) - (pop ? ONE_C : '0);
            end
         end

         ST_DRAIN: begin
            fptr_d = IADDR;
            if (MEM_RVALID && (drop_q != '0)) begin
               drop_d = drop_q - ONE_C;
               if (drop_q == ONE_C) begin
                  state_d = ST_RUN;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous reset of every control field and entry.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         fptr_q       <= 32'h0;
         count_q      <= '0;
         nfill_q      <= '0;
         drop_q       <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         fill_q       <= '0;
         ent_filled_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr_q[i] <= 32'h0;
            ent_data_q[i] <= 32'h0;
         end
      end else begin
         state_q      <= state_d;
         fptr_q       <= fptr_d;
         count_q      <= count_d;
         nfill_q      <= nfill_d;
         drop_q       <= drop_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         fill_q       <= fill_d;
         ent_filled_q <= ent_filled_d;
         ent_addr_q   <= ent_addr_d;
         ent_data_q   <= ent_data_d;
      end
   end

endmodule

// File: tb/tb_imem_prefetch.sv
// Self-checking bench for imem_prefetch: a behavioural instruction memory with
// configurable grant pattern and in-order response delay, a scripted core, and
// directed scenarios with hand-derived expected values.
module tb_imem_prefetch;

   localparam int DEPTH = 4;

   logic        CLK;
   logic        RST;
   logic [31:0] IADDR;
   logic [31:0] IDATA;
   logic        IVALID;
   logic        MEM_REQ;
   logic [31:0] MEM_ADDR;
   logic        MEM_GNT;
   logic        MEM_RVALID;
   logic [31:0] MEM_RDATA;

   typedef struct {
      logic [31:0] addr;
      int          ready;
   } resp_t;

   resp_t       pend[$];
   int          cyc;
   int          lastReady;
   int          dMin;
   int          dMax;
   logic        gntRandom;
   logic        sReq;
   logic [31:0] sAddr;
   logic        sIvalid;
   logic [31:0] sIdata;
   logic        sRvalid;
   logic [31:0] coreAddr;
   int          checks;
   int          failures;

   imem_prefetch #(.DEPTH(DEPTH)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .IADDR      (IADDR),
      .IDATA      (IDATA),
      .IVALID     (IVALID),
      .MEM_REQ    (MEM_REQ),
      .MEM_ADDR   (MEM_ADDR),
      .MEM_GNT    (MEM_GNT),
      .MEM_RVALID (MEM_RVALID),
      .MEM_RDATA  (MEM_RDATA)
   );

   // Free-running clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Instruction memory contents as a pure function of the address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive core address, reset and memory response at the falling
   // edge, let logic settle, sample outputs, and book any grant in the memory model.
   task automatic applyStimulus(input logic [31:0] addr, input logic rst);
      int d;
      int r;
      @(negedge CLK);
      RST        = rst;
      IADDR      = addr;
      MEM_RVALID = 1'b0;
      MEM_RDATA  = 32'h0;
      if (!rst && pend.size() > 0) begin
         if (pend[0].ready <= cyc) begin
            MEM_RVALID = 1'b1;
            MEM_RDATA  = memf(pend[0].addr);
            void'(pend.pop_front());
         end
      end
      MEM_GNT = gntRandom ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      sReq    = MEM_REQ;
      sAddr   = MEM_ADDR;
      sIvalid = IVALID;
      sIdata  = IDATA;
      sRvalid = MEM_RVALID;
      if (rst) begin
         pend.delete();
         lastReady = cyc;
      end else if (sReq && MEM_GNT) begin
         d = int'($urandom_range(dMax, dMin));
         r = cyc + d;
         if (r <= lastReady) r = lastReady + 1;
         pend.push_back('{addr: sAddr, ready: r});
         lastReady = r;
      end
      cyc++;
   endtask

   // Sequential core: advance by one word after each delivered instruction until target.
   task automatic coreRun(input logic [31:0] target, input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         applyStimulus(coreAddr, 1'b0);
         if (sIvalid) begin
            checkOutput("seqData", sIdata, memf(coreAddr));
            if (coreAddr == target) done = 1'b1;
            else coreAddr = coreAddr + 32'd4;
         end
      end
      checkOutput("seqReach", {31'h0, done}, 32'h1);
   endtask

   initial begin
      int staleCnt;
      int delivered;
      int idle;
      logic stuck;
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      lastReady = 0;
      gntRandom = 1'b0;
      dMin      = 1;
      dMax      = 1;
      RST       = 1'b1;
      IADDR     = 32'h0;
      MEM_GNT   = 1'b0;
      MEM_RVALID = 1'b0;
      MEM_RDATA = 32'h0;

      // Reset, first fetch latency and sequential delivery.
      applyStimulus(32'h0, 1'b1);
      applyStimulus(32'h0, 1'b1);
      applyStimulus(32'h0, 1'b0);
      checkOutput("rstReq", {31'h0, sReq}, 32'h0);
      checkOutput("rstAddr", sAddr, 32'h0);
      checkOutput("rstIvalid", {31'h0, sIvalid}, 32'h0);
      checkOutput("rstIdata", sIdata, 32'h0);
      applyStimulus(32'h0, 1'b0);
      checkOutput("req1", {31'h0, sReq}, 32'h1);
      checkOutput("addr1", sAddr, 32'h0);
      applyStimulus(32'h0, 1'b0);
      checkOutput("ivalid2", {31'h0, sIvalid}, 32'h0);
      checkOutput("addr2", sAddr, 32'h4);
      applyStimulus(32'h0, 1'b0);
      checkOutput("ivalid3", {31'h0, sIvalid}, 32'h1);
      checkOutput("idata3", sIdata, memf(32'h0));
      coreAddr = 32'h4;
      coreRun(32'h8, 40);

      // Stall at 0x8: hit retained, buffer fills and requests stop.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(32'h8, 1'b0);
         checkOutput("stallValid", {31'h0, sIvalid}, 32'h1);
         checkOutput("stallData", sIdata, memf(32'h8));
         if (i >= 3) checkOutput("fullReq", {31'h0, sReq}, 32'h0);
      end
      checkOutput("fullAddr", sAddr, 32'h18);

      // Redirect to 0x200 with two responses still outstanding.
      dMin = 4;
      dMax = 4;
      applyStimulus(32'hC, 1'b0);
      checkOutput("popIvalid", {31'h0, sIvalid}, 32'h0);
      checkOutput("popReq", {31'h0, sReq}, 32'h0);
      applyStimulus(32'hC, 1'b0);
      checkOutput("hitC", sIdata, memf(32'hC));
      checkOutput("reqB", sAddr, 32'h18);
      applyStimulus(32'h10, 1'b0);
      applyStimulus(32'h10, 1'b0);
      checkOutput("hit10", sIdata, memf(32'h10));
      checkOutput("reqD", sAddr, 32'h1C);
      applyStimulus(32'h200, 1'b0);
      checkOutput("redirReq", {31'h0, sReq}, 32'h0);
      checkOutput("redirIvalid", {31'h0, sIvalid}, 32'h0);
      staleCnt = 0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(32'h200, 1'b0);
         checkOutput("drainReq", {31'h0, sReq}, 32'h0);
         checkOutput("drainIvalid", {31'h0, sIvalid}, 32'h0);
         if (sRvalid) staleCnt++;
      end
      checkOutput("staleCnt", staleCnt, 32'd2);
      dMin = 1;
      dMax = 1;
      applyStimulus(32'h200, 1'b0);
      checkOutput("newReq", {31'h0, sReq}, 32'h1);
      checkOutput("newAddr", sAddr, 32'h200);
      applyStimulus(32'h200, 1'b0);
      applyStimulus(32'h200, 1'b0);
      checkOutput("newValid", {31'h0, sIvalid}, 32'h1);
      checkOutput("newData", sIdata, memf(32'h200));

      // Random grants, random response delay, occasional jumps.
      gntRandom = 1'b1;
      dMin      = 1;
      dMax      = 3;
      coreAddr  = 32'h204;
      delivered = 0;
      idle      = 0;
      stuck     = 1'b0;
      for (int i = 0; i < 400 && !stuck; i++) begin
         applyStimulus(coreAddr, 1'b0);
         checkOutput("outstanding", {31'h0, pend.size() <= DEPTH}, 32'h1);
         if (sIvalid) begin
            checkOutput("rndData", sIdata, memf(coreAddr));
            delivered++;
            idle = 0;
            if ($urandom_range(0, 19) == 0) coreAddr = 32'h1000 + ($urandom_range(0, 255) << 2);
            else coreAddr = coreAddr + 32'd4;
         end else begin
            idle++;
            if (idle > 40) stuck = 1'b1;
         end
      end
      checkOutput("rndStall", {31'h0, stuck}, 32'h0);
      checkOutput("rndDelivered", {31'h0, delivered >= 30}, 32'h1);

      // Fetch pointer wrap across the top of the address space.
      gntRandom = 1'b0;
      dMin      = 1;
      dMax      = 1;
      applyStimulus(32'hFFFF_FFF8, 1'b1);
      applyStimulus(32'hFFFF_FFF8, 1'b0);
      applyStimulus(32'hFFFF_FFF8, 1'b0);
      checkOutput("wrapReq0", {31'h0, sReq}, 32'h1);
      checkOutput("wrapAddr0", sAddr, 32'hFFFF_FFF8);
      applyStimulus(32'hFFFF_FFF8, 1'b0);
      checkOutput("wrapAddr1", sAddr, 32'hFFFF_FFFC);
      applyStimulus(32'hFFFF_FFF8, 1'b0);
      checkOutput("wrapReq2", {31'h0, sReq}, 32'h1);
      checkOutput("wrapAddr2", sAddr, 32'h0);
      checkOutput("wrapData", sIdata, memf(32'hFFFF_FFF8));
      coreAddr = 32'hFFFF_FFFC;
      coreRun(32'h0, 20);

      // Reset asserted while draining two stale responses.
      dMin = 4;
      dMax = 4;
      applyStimulus(32'h300, 1'b1);
      applyStimulus(32'h300, 1'b0);
      applyStimulus(32'h300, 1'b0);
      checkOutput("r6Addr1", sAddr, 32'h300);
      applyStimulus(32'h300, 1'b0);
      checkOutput("r6Addr2", sAddr, 32'h304);
      applyStimulus(32'h400, 1'b0);
      checkOutput("r6Redir", {31'h0, sReq}, 32'h0);
      applyStimulus(32'h400, 1'b1);
      checkOutput("r6Drain", {31'h0, sReq}, 32'h0);
      dMin = 1;
      dMax = 1;
      applyStimulus(32'h400, 1'b0);
      checkOutput("r6IdleReq", {31'h0, sReq}, 32'h0);
      checkOutput("r6IdleAddr", sAddr, 32'h0);
      checkOutput("r6IdleValid", {31'h0, sIvalid}, 32'h0);
      checkOutput("r6IdleData", sIdata, 32'h0);
      applyStimulus(32'h400, 1'b0);
      checkOutput("r6Req", {31'h0, sReq}, 32'h1);
      checkOutput("r6ReqAddr", sAddr, 32'h400);
      applyStimulus(32'h400, 1'b0);
      applyStimulus(32'h400, 1'b0);
      checkOutput("r6Valid", {31'h0, sIvalid}, 32'h1);
      checkOutput("r6Data", sIdata, memf(32'h400));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
